// File: rtl/data_mem_responder.sv
// Zero-wait-state data-memory target for the MEM-stage port.
// Stores go through a small circular store buffer that drains to the word array in idle cycles.
module data_mem_responder #(
    parameter int ADDR_W    = 10,
    parameter int STB_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  memAddr,
    input  logic [31:0]                  memWrData,
    input  logic                         memWr,
    input  logic [1:0]                   dataSize,
    output logic [31:0]                  memRdData,
    output logic [$clog2(STB_DEPTH):0]   stbCount,
    output logic                         stbFull,
    output logic                         alignErr
);

    localparam int PTR_W = $clog2(STB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 2 ** ADDR_W;

    logic [31:0]       mem_q      [WORDS];
    logic [ADDR_W-1:0] stb_addr_q [STB_DEPTH];
    logic [31:0]       stb_data_q [STB_DEPTH];
    logic [3:0]        stb_mask_q [STB_DEPTH];
    logic [STB_DEPTH-1:0] stb_vld_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              align_err_q;

    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        st_mask;
    logic [31:0]       st_data;
    logic              misalign;
    logic              full;
    logic              do_enq;
    logic              do_drain;
    logic              unused_addr_bits;

    assign word_addr        = memAddr[ADDR_W+1:2];
    assign unused_addr_bits = ^memAddr[31:ADDR_W+2];

    // Store data is replicated across lanes so the mask alone selects the target bytes.
    always_comb begin
        st_mask  = 4'b0000;
        st_data  = 32'h0;
        misalign = 1'b0;
        case (dataSize)
            2'b00: begin
                st_mask = 4'b1000 >> memAddr[1:0];
                st_data = {4{memWrData[7:0]}};
            end
            2'b01: begin
                misalign = memAddr[0];
                st_mask  = memAddr[1] ? 4'b0011 : 4'b1100;
                st_data  = {2{memWrData[15:0]}};
            end
            default: begin
                misalign = (memAddr[1:0] != 2'b00);
                st_mask  = 4'b1111;
                st_data  = memWrData;
            end
        endcase
    end

    assign full     = (count_q == CNT_W'(STB_DEPTH));
    assign do_enq   = memWr & ~misalign;
    assign do_drain = do_enq ? full : (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            stb_vld_q   <= '0;
            align_err_q <= 1'b0;
            for (int i = 0; i < STB_DEPTH; i++) begin
                stb_addr_q[i] <= '0;
                stb_data_q[i] <= '0;
                stb_mask_q[i] <= '0;
            end
        end else begin
            if (memWr && misalign) begin
                align_err_q <= 1'b1;
            end
            // When full, head == tail: the enqueue below re-sets the valid bit the drain clears.
            if (do_drain) begin
                stb_vld_q[head_q] <= 1'b0;
                head_q            <= head_q + PTR_W'(1);
            end
            if (do_enq) begin
                stb_addr_q[tail_q] <= word_addr;
                stb_data_q[tail_q] <= st_data;
                stb_mask_q[tail_q] <= st_mask;
                stb_vld_q[tail_q]  <= 1'b1;
                tail_q             <= tail_q + PTR_W'(1);
            end
            case ({do_enq, do_drain})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_drain) begin
            for (int b = 0; b < 4; b++) begin
                if (stb_mask_q[head_q][b]) begin
                    mem_q[stb_addr_q[head_q]][b*8 +: 8] <= stb_data_q[head_q][b*8 +: 8];
                end
            end
        end
    end

    // Walk the buffer oldest to youngest so the youngest store wins each lane.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        memRdData = mem_q[word_addr];
        for (int i = 0; i < STB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (stb_vld_q[idx] && (stb_addr_q[idx] == word_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (stb_mask_q[idx][b]) begin
                        memRdData[b*8 +: 8] = stb_data_q[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign stbCount = count_q;
    assign stbFull  = full;
    assign alignErr = align_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: byte-level architectural memory model plus
// a read scoreboard; expected words are queued when a load is driven and popped at sampling.
module tb_data_mem_responder;

    localparam int ADDR_W    = 10;
    localparam int STB_DEPTH = 4;
    localparam int AMASK     = (1 << (ADDR_W + 2)) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] memWrData = '0;
    logic        memWr = 1'b0;
    logic [1:0]  dataSize = 2'b00;
    logic [31:0] memRdData;
    logic [$clog2(STB_DEPTH):0] stbCount;
    logic        stbFull;
    logic        alignErr;

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;
    logic        exp_err = 1'b0;
    logic [31:0] last_rd;
    logic [31:0] sb_q[$];
    logic [7:0]  mdl[int];

    data_mem_responder #(.ADDR_W(ADDR_W), .STB_DEPTH(STB_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .memAddr(memAddr), .memWrData(memWrData),
        .memWr(memWr), .dataSize(dataSize), .memRdData(memRdData),
        .stbCount(stbCount), .stbFull(stbFull), .alignErr(alignErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [31:0] w;
        int          base;
        w    = '0;
        base = int'(addr) & AMASK & ~3;
        for (int k = 0; k < 4; k++) begin
            if (mdl.exists(base + k)) w[31-8*k -: 8] = mdl[base + k];
        end
        return w;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        int a;
        a = int'(addr) & AMASK;
        if (size == 2'b00) begin
            mdl[a] = data[7:0];
        end else if (size == 2'b01) begin
            mdl[a]     = data[15:8];
            mdl[a + 1] = data[7:0];
        end else begin
            for (int k = 0; k < 4; k++) mdl[a + k] = data[31-8*k -: 8];
        end
    endtask

    task automatic status(input string tag);
        check({tag, "_cnt"}, 32'(stbCount), 32'(exp_cnt));
        check({tag, "_full"}, 32'(stbFull), 32'(exp_cnt == STB_DEPTH));
        check({tag, "_err"}, 32'(alignErr), 32'(exp_err));
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                      input bit upd_model);
        logic mis;
        @(negedge clk);
        status("st");
        memWr     = 1'b1;
        memAddr   = addr;
        memWrData = data;
        dataSize  = size;
        mis = (size == 2'b00) ? 1'b0 : (size == 2'b01) ? addr[0] : (addr[1:0] != 2'b00);
        if (mis) begin
            exp_err = 1'b1;
            if (exp_cnt > 0) exp_cnt--;
        end else begin
            if (upd_model) model_store(addr, data, size);
            if (exp_cnt < STB_DEPTH) exp_cnt++;
        end
    endtask

    task automatic idle_rd(input logic [31:0] addr);
        @(negedge clk);
        memWr     = 1'b0;
        memAddr   = addr;
        memWrData = $urandom;
        dataSize  = 2'($urandom_range(0, 3));
        sb_q.push_back(model_word(addr));
        #2;
        status("rd");
        last_rd = memRdData;
        check("rd_data", memRdData, sb_q.pop_front());
        if (exp_cnt > 0) exp_cnt--;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        status("reset");
        rst_n = 1'b1;

        // T1: byte store forwarding, then drain into array
        st(32'h0, 32'h11223344, 2'b11, 1'b1);
        idle_rd(32'h0);
        st(32'h1, 32'h000000AA, 2'b00, 1'b1);
        idle_rd(32'h0);
        check("T1_fwd", last_rd, 32'h11AA3344);
        idle_rd(32'h0);
        check("T1_arr", dut.mem_q[0], 32'h11AA3344);

        // T2: fill buffer, forced drain on the fifth store
        for (int i = 0; i < 4; i++) st(32'(4 * i), 32'hA0 + 32'(i), 2'b11, 1'b1);
        st(32'h10, 32'hA4, 2'b11, 1'b1);
        check("T2_full", 32'(stbFull), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            idle_rd(32'(4 * i));
            check("T2_rd", last_rd, 32'hA0 + 32'(i));
        end
        check("T2_arr0", dut.mem_q[0], 32'hA0);

        // T3: same-word half then byte, youngest wins per lane
        st(32'h0, 32'hCAFEF00D, 2'b11, 1'b1);
        idle_rd(32'h0);
        st(32'h2, 32'h0000BEEF, 2'b01, 1'b1);
        st(32'h3, 32'h00000055, 2'b00, 1'b1);
        idle_rd(32'h0);
        check("T3_fwd", last_rd, 32'hCAFEBE55);
        idle_rd(32'h0);
        idle_rd(32'h0);
        check("T3_arr", dut.mem_q[0], 32'hCAFEBE55);

        // T4: misaligned stores are dropped and flag sticks
        st(32'h6, 32'hDEADBEEF, 2'b11, 1'b1);
        st(32'h5, 32'h00001234, 2'b01, 1'b1);
        idle_rd(32'h4);
        check("T4_rd", last_rd, 32'hA1);
        check("T4_arr", dut.mem_q[1], 32'hA1);
        idle_rd(32'h4);
        idle_rd(32'h4);

        // T5: async reset with three buffered stores
        for (int i = 0; i < 3; i++) st(32'h100 + 32'(4 * i), 32'h5000 + 32'(i), 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) idle_rd(32'h100 + 32'(4 * i));
        for (int i = 0; i < 3; i++) st(32'h100 + 32'(4 * i), 32'h6000 + 32'(i), 2'b11, 1'b0);
        @(negedge clk);
        memWr = 1'b0;
        #2;
        check("T5_pre_cnt", 32'(stbCount), 32'd3);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        exp_err = 1'b0;
        status("T5_async");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_rd(32'h100 + 32'(4 * i));
            check("T5_lost", last_rd, 32'h5000 + 32'(i));
        end

        // Pointer wrap with store/idle pairs; alias high address bits and mixed word encodings
        for (int i = 0; i < 2 * STB_DEPTH + 1; i++) begin
            logic [31:0] d;
            d = $urandom;
            st(32'h0010_0200 + 32'(4 * i), d, (i % 2 == 1) ? 2'b10 : 2'b11, 1'b1);
            idle_rd(32'h200 + 32'(4 * i));
            check("wrap_rd", last_rd, d);
        end
        idle_rd(32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
